// File: rtl/pc_gen_unit_pkg.sv
// Shared types and constants for the PC generation stage: FSM encoding, PC step,
// perf-counter width and a saturating-increment helper.
package pc_gen_unit_pkg;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } state_e;

   localparam logic [31:0] PC_STEP = 32'd4;
   localparam int unsigned CNT_W = 16;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
      return (en && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
   endfunction

endpackage

// File: rtl/pc_gen_unit_if.sv
// Bundle of EX-stage resolution inputs and fetch/flush/perf outputs of pc_gen_unit.
// The slave modport is the PC unit; the master modport drives EX info and consumes fetch.
interface pc_gen_unit_if
   import pc_gen_unit_pkg::*;
();
   logic             stall;
   logic             ex_valid;
   logic             ex_is_branch;
   logic             ex_is_jump;
   logic             ex_taken;
   logic [31:0]      ex_pc;
   logic [31:0]      ex_target;
   logic             ex_pred_taken;
   logic [31:0]      ex_pred_target;
   logic [31:0]      if_pc;
   logic             if_valid;
   logic             if_pred_taken;
   logic [31:0]      if_pred_target;
   logic             flush;
   logic [CNT_W-1:0] branch_cnt;
   logic [CNT_W-1:0] mispred_cnt;

   modport master (
      output stall, ex_valid, ex_is_branch, ex_is_jump, ex_taken, ex_pc, ex_target,
             ex_pred_taken, ex_pred_target,
      input  if_pc, if_valid, if_pred_taken, if_pred_target, flush, branch_cnt, mispred_cnt
   );

   modport slave (
      input  stall, ex_valid, ex_is_branch, ex_is_jump, ex_taken, ex_pc, ex_target,
             ex_pred_taken, ex_pred_target,
      output if_pc, if_valid, if_pred_taken, if_pred_target, flush, branch_cnt, mispred_cnt
   );
endinterface

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer: combinational lookup on the fetch PC,
// write/invalidate at the edge ending an EX resolution. Only used when PC_BTB_EN is defined.
module pc_btb #(
   parameter int unsigned ENTRIES = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] lookup_pc,
   output logic        hit,
   output logic [31:0] hit_target,
   input  logic        upd_valid,
   input  logic        upd_taken,
   input  logic        upd_is_branch,
   input  logic [31:0] upd_pc,
   input  logic [31:0] upd_target
);
   localparam int unsigned IDX_W = $clog2(ENTRIES);
   localparam int unsigned TAG_W = 30 - IDX_W;

   logic [ENTRIES-1:0] valid_q;
   logic [TAG_W-1:0]   tag_q    [ENTRIES];
   logic [31:0]        target_q [ENTRIES];

   logic [IDX_W-1:0] lk_idx, up_idx;
   logic [TAG_W-1:0] lk_tag, up_tag;
   logic             unused_lsbs;

   assign lk_idx      = lookup_pc[IDX_W+1:2];
   assign lk_tag      = lookup_pc[31:IDX_W+2];
   assign up_idx      = upd_pc[IDX_W+1:2];
   assign up_tag      = upd_pc[31:IDX_W+2];
   assign unused_lsbs = ^{lookup_pc[1:0], upd_pc[1:0]};

   // Reads see pre-edge contents, so a same-cycle update is invisible to the lookup.
   assign hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
   assign hit_target = target_q[lk_idx];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= '0;
      end else if (upd_valid) begin
         if (upd_taken) begin
            valid_q[up_idx] <= 1'b1;
         end else if (upd_is_branch && (tag_q[up_idx] == up_tag)) begin
            valid_q[up_idx] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (upd_valid && upd_taken) begin
         tag_q[up_idx]    <= up_tag;
         target_q[up_idx] <= upd_target;
      end
   end
endmodule

// File: rtl/pc_gen_unit.sv
// Fetch PC generation with branch resolution, redirect/flush and saturating perf counters.
// Define PC_BTB_EN to add a direct-mapped BTB; otherwise fetch is static predict-not-taken.
module pc_gen_unit
   import pc_gen_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int unsigned BTB_ENTRIES = 8
) (
   input logic          clk,
   input logic          rst_n,
   pc_gen_unit_if.slave bus
);
   state_e           state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic [CNT_W-1:0] bcnt_q, mcnt_q;
   logic             actual_taken, mispredict;
   logic [31:0]      redirect_pc;
   logic             pred_taken;
   logic [31:0]      pred_target;

   if ((BTB_ENTRIES < 2) || ((BTB_ENTRIES & (BTB_ENTRIES - 1)) != 0)) begin : g_bad_btb_cfg
      $error("BTB_ENTRIES must be a power of two >= 2");
   end

   assign actual_taken = bus.ex_is_jump | (bus.ex_is_branch & bus.ex_taken);
   assign mispredict   = bus.ex_valid & ((actual_taken != bus.ex_pred_taken) |
                         (actual_taken & (bus.ex_pred_target != bus.ex_target)));
   assign redirect_pc  = actual_taken ? bus.ex_target : bus.ex_pc + PC_STEP;

`ifdef PC_BTB_EN
   logic        btb_hit;
   logic [31:0] btb_target;

   pc_btb #(
      .ENTRIES(BTB_ENTRIES)
   ) u_btb (
      .clk          (clk),
      .rst_n        (rst_n),
      .lookup_pc    (pc_q),
      .hit          (btb_hit),
      .hit_target   (btb_target),
      .upd_valid    (bus.ex_valid),
      .upd_taken    (actual_taken),
      .upd_is_branch(bus.ex_is_branch),
      .upd_pc       (bus.ex_pc),
      .upd_target   (bus.ex_target)
   );

   assign pred_taken  = btb_hit;
   assign pred_target = btb_hit ? btb_target : pc_q + PC_STEP;
`else
   assign pred_taken  = 1'b0;
   assign pred_target = pc_q + PC_STEP;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_BOOT;
         pc_q    <= RESET_PC;
         bcnt_q  <= '0;
         mcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         bcnt_q  <= sat_inc(bcnt_q, bus.ex_valid);
         mcnt_q  <= sat_inc(mcnt_q, mispredict);
      end
   end

   // Mispredict beats stall; BOOT leaves for RUN without advancing the PC.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      if (mispredict) begin
         state_d = ST_FLUSH;
         pc_d    = redirect_pc;
      end else if (!bus.stall) begin
         unique case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN, ST_FLUSH: begin
               state_d = ST_RUN;
               pc_d    = pred_target;
            end
            default: state_d = ST_BOOT;
         endcase
      end
   end

   always_comb begin
      bus.if_pc          = pc_q;
      bus.if_valid       = (state_q != ST_BOOT);
      bus.if_pred_taken  = pred_taken;
      bus.if_pred_target = pred_target;
      bus.flush          = (state_q == ST_FLUSH);
      bus.branch_cnt     = bcnt_q;
      bus.mispred_cnt    = mcnt_q;
   end
endmodule

// File: doc/pc_gen_unit.md
# pc_gen_unit

Program-counter generation and branch-resolution stage for the RISC-V core. It consumes the branch comparator's taken/not-taken result and the EX-stage target address, and drives the fetch PC. It detects mispredictions and redirects fetch, issuing a registered flush to the IF/ID stages. It also keeps saturating branch and mispredict counters for performance monitoring.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- BTB_ENTRIES, 8, BTB depth; power of two; used only when PC_BTB_EN is defined
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- stall  in  1  hold current if_pc (pipeline hazard)
- ex_valid  in  1  EX holds a control-flow instruction this cycle; asserted exactly once per instruction
- ex_is_branch  in  1  conditional branch (BEQ/BNE/BLT/BGE/BLTU/BGEU)
- ex_is_jump  in  1  JAL/JALR
- ex_taken  in  1  branch comparator output
- ex_pc  in  32  PC of the EX instruction
- ex_target  in  32  computed target; JALR LSB already cleared
- ex_pred_taken  in  1  prediction carried down with the instruction
- ex_pred_target  in  32  predicted target carried down; ignored when ex_pred_taken=0
- if_pc  out  32  fetch address
- if_valid  out  1  if_pc is a real fetch
- if_pred_taken  out  1  prediction for if_pc
- if_pred_target  out  32  predicted next PC for if_pc
- flush  out  1  kill IF/ID contents (registered)
- branch_cnt  out  16  resolved branches+jumps, saturating
- mispred_cnt  out  16  mispredictions, saturating

## Operation
- actual_taken = ex_is_jump | (ex_is_branch & ex_taken).
- mispredict = ex_valid & ((actual_taken != ex_pred_taken) | (actual_taken & ex_pred_target != ex_target)).
- redirect_pc = actual_taken ? ex_target : ex_pc + 4. All PC arithmetic is modulo 2^32; wrap from FFFF_FFFC to 0 is legal.
- Next-PC priority: reset > mispredict (redirect_pc) > stall (hold) > prediction (if_pred_target) > if_pc + 4.
- Mispredict overrides stall.
- FSM states:
  - BOOT: entered on reset; if_valid=0; next state RUN, with no PC advance.
  - RUN: normal operation; a mispredict moves to FLUSH.
  - FLUSH: lasts one cycle, flush=1; next state RUN, or FLUSH again if another mispredict occurs.
- if_valid=1 in RUN and FLUSH.
- Counters:
  - branch_cnt increments on every ex_valid.
  - mispred_cnt increments on every mispredict.
  - Both hold at 16'hFFFF.
- Reset values: if_pc=RESET_PC, if_valid=0, flush=0, both counters 0, if_pred_taken=0, if_pred_target=RESET_PC+4, BTB all invalid, state BOOT.

## Timing
- Mispredict seen in cycle N: if_pc=redirect_pc and flush=1 in cycle N+1. Redirect penalty is 2 cycles.
- Predicted-taken fetch: if_pc=target in the cycle after lookup, with zero bubbles.
- stall=1 without mispredict: if_pc, state and prediction outputs are unchanged next cycle.
- Reset mid-operation: rst_n=0 at any edge restores all reset values regardless of stall, mispredict or FLUSH.
- Counters update at the edge ending the ex_valid cycle.

## Configuration
- PC_BTB_EN defined: direct-mapped BTB of BTB_ENTRIES entries, each {valid, tag, target}.
  - Indexing: index = pc[log2(BTB_ENTRIES)+1:2]; tag = remaining upper bits.
  - Lookup is combinational on if_pc; a hit gives if_pred_taken=1 and if_pred_target=entry target.
  - Update at the edge ending an ex_valid cycle, indexed by ex_pc:
    - actual_taken: write {1, tag, ex_target}.
    - not-taken branch: clear valid if the tag matches.
  - Lookup and update in the same cycle to the same index: lookup returns the old contents.
- PC_BTB_EN undefined: no BTB storage; if_pred_taken=0 and if_pred_target=if_pc+4 (static predict-not-taken).

## Structure
- Shared package/const header holds:
  - FSM state encodings (ST_BOOT, ST_RUN, ST_FLUSH).
  - PC_STEP=4.
  - Counter width 16.
- One natural sub-module: pc_btb (storage, lookup, update), instantiated only under PC_BTB_EN.

## Test plan
- Reset release:
  - Hold rst_n=0 for 3 cycles, then release.
  - if_pc=0, if_valid=0 for 1 cycle.
  - Then if_pc=0, 4, 8 with if_valid=1.
- Not-taken branch, correctly predicted:
  - ex_valid, ex_is_branch, ex_taken=0, ex_pred_taken=0.
  - No flush; branch_cnt=1; mispred_cnt=0.
- Taken BEQ mispredict:
  - ex_pc=0x100, ex_target=0x80, ex_taken=1, pred 0.
  - Next cycle if_pc=0x80, flush=1; mispred_cnt=1.
- Mispredict during stall:
  - stall=1 with a JAL to 0x200.
  - Redirect wins: if_pc=0x200 next cycle.
- Counter saturation:
  - Drive 65,537 mispredicts.
  - mispred_cnt=0xFFFF, branch_cnt=0xFFFF.
- PC_BTB_EN:
  - Resolve taken branch at 0x40 to 0x10.
  - When fetch later reaches 0x40: if_pred_taken=1 and the next if_pc is 0x10.
  - A correct resolution of that branch produces no flush.
